// File: rtl/signed_peak_tracker.sv
// Frame-based running-maximum tracker for a stream of signed samples, with a valid/ready result port.
// Optional frame-minimum tracking is enabled by defining SIGNED_PEAK_TRACKER_MIN_EN.
module signed_peak_tracker #(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 16,
    parameter int IDX_WIDTH = 4
) (
    input  logic                        CLK,
    input  logic                        RESETN,
    input  logic                        I_VALID,
    output logic                        I_READY,
    input  logic signed [WIDTH-1:0]     I,
    output logic                        O_VALID,
    input  logic                        O_READY,
    output logic signed [WIDTH-1:0]     O_MAX,
    output logic        [IDX_WIDTH-1:0] O_IDX
`ifdef SIGNED_PEAK_TRACKER_MIN_EN
    ,
    output logic signed [WIDTH-1:0]     O_MIN,
    output logic        [IDX_WIDTH-1:0] O_MIN_IDX
`endif
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(FRAME_LEN - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t state;
    state_t next_state;

    logic        [IDX_WIDTH-1:0] count;
    logic signed [WIDTH-1:0]     max_val;
    logic        [IDX_WIDTH-1:0] max_idx;

    logic                        accept;
    logic                        last;
    logic                        first;
    logic                        take_max;
    logic signed [WIDTH-1:0]     sel_max;
    logic        [IDX_WIDTH-1:0] sel_max_idx;

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state <= ACCUM;
        end else begin
            state <= next_state;
        end
    end

    // HOLD is left only on the result handshake; ready depends on state alone.
    always_comb begin
        next_state = state;
        I_READY    = 1'b0;
        case (state)
            ACCUM: begin
                I_READY = 1'b1;
                if (I_VALID && count == LAST_IDX) begin
                    next_state = HOLD;
                end
            end
            HOLD: begin
                if (O_READY) begin
                    next_state = ACCUM;
                end
            end
            default: next_state = ACCUM;
        endcase
    end

    assign accept = I_VALID && (state == ACCUM);
    assign last   = (count == LAST_IDX);
    assign first  = (count == '0);

    // The first sample of a frame always loads; later ones need a strict signed win, so ties keep the earlier index.
    assign take_max    = first || (I > max_val);
    assign sel_max     = take_max ? I : max_val;
    assign sel_max_idx = take_max ? count : max_idx;

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            count   <= '0;
            max_val <= '0;
            max_idx <= '0;
            O_VALID <= 1'b0;
            O_MAX   <= '0;
            O_IDX   <= '0;
        end else begin
            if (accept) begin
                max_val <= sel_max;
                max_idx <= sel_max_idx;
                if (last) begin
                    count   <= '0;
                    O_VALID <= 1'b1;
                    O_MAX   <= sel_max;
                    O_IDX   <= sel_max_idx;
                end else begin
                    count <= count + 1'b1;
                end
            end else if (O_VALID && O_READY) begin
                O_VALID <= 1'b0;
            end
        end
    end

`ifdef SIGNED_PEAK_TRACKER_MIN_EN
    logic signed [WIDTH-1:0]     min_val;
    logic        [IDX_WIDTH-1:0] min_idx;
    logic                        take_min;
    logic signed [WIDTH-1:0]     sel_min;
    logic        [IDX_WIDTH-1:0] sel_min_idx;

    assign take_min    = first || (I < min_val);
    assign sel_min     = take_min ? I : min_val;
    assign sel_min_idx = take_min ? count : min_idx;

    // Minimum results share the max's O_VALID qualification.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            min_val   <= '0;
            min_idx   <= '0;
            O_MIN     <= '0;
            O_MIN_IDX <= '0;
        end else if (accept) begin
            min_val <= sel_min;
            min_idx <= sel_min_idx;
            if (last) begin
                O_MIN     <= sel_min;
                O_MIN_IDX <= sel_min_idx;
            end
        end
    end
`else
    // Maximum-only build: no minimum registers exist.
`endif

endmodule

// File: tb/tb_signed_peak_tracker.sv
// Randomised and directed self-checking bench for signed_peak_tracker with FRAME_LEN=4.
module tb_signed_peak_tracker;

    localparam int W  = 8;
    localparam int FL = 4;
    localparam int IW = 2;

    logic                 CLK;
    logic                 RESETN;
    logic                 I_VALID;
    logic                 I_READY;
    logic signed [W-1:0]  I;
    logic                 O_VALID;
    logic                 O_READY;
    logic signed [W-1:0]  O_MAX;
    logic        [IW-1:0] O_IDX;
`ifdef SIGNED_PEAK_TRACKER_MIN_EN
    logic signed [W-1:0]  O_MIN;
    logic        [IW-1:0] O_MIN_IDX;
`endif

    int n_cmp;
    int n_err;

    signed_peak_tracker #(
        .WIDTH(W),
        .FRAME_LEN(FL),
        .IDX_WIDTH(IW)
    ) dut (
        .CLK(CLK),
        .RESETN(RESETN),
        .I_VALID(I_VALID),
        .I_READY(I_READY),
        .I(I),
        .O_VALID(O_VALID),
        .O_READY(O_READY),
        .O_MAX(O_MAX),
        .O_IDX(O_IDX)
`ifdef SIGNED_PEAK_TRACKER_MIN_EN
        ,
        .O_MIN(O_MIN),
        .O_MIN_IDX(O_MIN_IDX)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference: scan a whole frame; strict compares keep the earliest index on ties.
    function automatic void frame_result(input logic signed [W-1:0] s[$],
                                         output logic signed [W-1:0] mx, output logic [IW-1:0] mxi,
                                         output logic signed [W-1:0] mn, output logic [IW-1:0] mni);
        mx = s[0]; mxi = '0; mn = s[0]; mni = '0;
        for (int k = 1; k < s.size(); k++) begin
            if (s[k] > mx) begin mx = s[k]; mxi = IW'(k); end
            if (s[k] < mn) begin mn = s[k]; mni = IW'(k); end
        end
    endfunction

    task automatic send(input logic signed [W-1:0] v);
        int guard;
        I_VALID = 1'b1;
        I = v;
        guard = 0;
        while (!I_READY && guard < 50) begin
            @(posedge CLK); #1;
            guard++;
        end
        if (guard >= 50) begin
            n_cmp++; n_err++;
            $display("[TB] FAIL send_timeout: I_READY=%0b required 1", I_READY);
        end
        @(posedge CLK); #1;
        I_VALID = 1'b0;
    endtask

    task automatic do_reset();
        RESETN = 1'b0;
        I_VALID = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RESETN = 1'b1;
    endtask

    task automatic test_reset();
        I_VALID = 1'b0; I = '0; O_READY = 1'b1;
        do_reset();
        n_cmp++; if (O_VALID !== 1'b0) begin n_err++; $display("[TB] FAIL reset_valid: got %0b want 0", O_VALID); end
        n_cmp++; if (O_MAX !== '0) begin n_err++; $display("[TB] FAIL reset_max: got %0d want 0", O_MAX); end
        n_cmp++; if (O_IDX !== '0) begin n_err++; $display("[TB] FAIL reset_idx: got %0d want 0", O_IDX); end
        n_cmp++; if (I_READY !== 1'b1) begin n_err++; $display("[TB] FAIL reset_ready: got %0b want 1", I_READY); end
    endtask

    // Rows: four samples, expected max, max idx, min, min idx.
    task automatic test_back_to_back();
        int tbl [6][8] = '{
            '{3, -5, 7, 2,          7, 2, -5, 1},
            '{-128, 127, -1, 0,     127, 1, -128, 0},
            '{-128, -128, -128, -128, -128, 0, -128, 0},
            '{5, 9, 9, 1,           9, 1, 1, 3},
            '{-3, 4, -3, 0,         4, 1, -3, 0},
            '{1, 2, 3, 4,           4, 3, 1, 0}
        };
        logic signed [W-1:0] emax;
        logic [IW-1:0]       eidx;
        O_READY = 1'b1;
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < FL; k++) send(W'(tbl[r][k]));
            emax = W'(tbl[r][4]);
            eidx = IW'(tbl[r][5]);
            n_cmp++; if (O_VALID !== 1'b1) begin n_err++; $display("[TB] FAIL b2b_valid row%0d: got %0b want 1", r, O_VALID); end
            n_cmp++; if (O_MAX !== emax) begin n_err++; $display("[TB] FAIL b2b_max row%0d: got %0d want %0d", r, O_MAX, emax); end
            n_cmp++; if (O_IDX !== eidx) begin n_err++; $display("[TB] FAIL b2b_idx row%0d: got %0d want %0d", r, O_IDX, eidx); end
            n_cmp++; if (I_READY !== 1'b0) begin n_err++; $display("[TB] FAIL b2b_ready_hold row%0d: got %0b want 0", r, I_READY); end
`ifdef SIGNED_PEAK_TRACKER_MIN_EN
            n_cmp++; if (O_MIN !== W'(tbl[r][6])) begin n_err++; $display("[TB] FAIL b2b_min row%0d: got %0d want %0d", r, O_MIN, tbl[r][6]); end
            n_cmp++; if (O_MIN_IDX !== IW'(tbl[r][7])) begin n_err++; $display("[TB] FAIL b2b_min_idx row%0d: got %0d want %0d", r, O_MIN_IDX, tbl[r][7]); end
`endif
            @(posedge CLK); #1;
            n_cmp++; if (O_VALID !== 1'b0) begin n_err++; $display("[TB] FAIL b2b_valid_drop row%0d: got %0b want 0", r, O_VALID); end
            n_cmp++; if (I_READY !== 1'b1) begin n_err++; $display("[TB] FAIL b2b_ready_back row%0d: got %0b want 1", r, I_READY); end
        end
    endtask

    task automatic test_backpressure();
        O_READY = 1'b0;
        send(8'sd10); send(8'sd20); send(8'sd30); send(8'sd40);
        I_VALID = 1'b1; I = 8'sd100;
        for (int c = 0; c < 5; c++) begin
            @(posedge CLK); #1;
            n_cmp++; if (O_VALID !== 1'b1) begin n_err++; $display("[TB] FAIL bp_valid c%0d: got %0b want 1", c, O_VALID); end
            n_cmp++; if (O_MAX !== 8'sd40) begin n_err++; $display("[TB] FAIL bp_max c%0d: got %0d want 40", c, O_MAX); end
            n_cmp++; if (O_IDX !== 2'd3) begin n_err++; $display("[TB] FAIL bp_idx c%0d: got %0d want 3", c, O_IDX); end
            n_cmp++; if (I_READY !== 1'b0) begin n_err++; $display("[TB] FAIL bp_ready c%0d: got %0b want 0", c, I_READY); end
        end
        O_READY = 1'b1;
        @(posedge CLK); #1;
        n_cmp++; if (O_VALID !== 1'b0) begin n_err++; $display("[TB] FAIL bp_release: got %0b want 0", O_VALID); end
        send(8'sd100); send(-8'sd1); send(-8'sd2); send(-8'sd3);
        n_cmp++; if (O_MAX !== 8'sd100 || O_IDX !== 2'd0 || O_VALID !== 1'b1) begin
            n_err++; $display("[TB] FAIL bp_next_frame: got max=%0d idx=%0d v=%0b want 100/0/1", O_MAX, O_IDX, O_VALID);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_reset_mid_frame();
        O_READY = 1'b1;
        send(8'sd50); send(8'sd60);
        RESETN = 1'b0;
        @(posedge CLK); #1;
        RESETN = 1'b1;
        n_cmp++; if (I_READY !== 1'b1 || O_VALID !== 1'b0) begin
            n_err++; $display("[TB] FAIL midreset_state: ready=%0b valid=%0b want 1/0", I_READY, O_VALID);
        end
        send(8'sd1); send(8'sd2); send(8'sd3);
        n_cmp++; if (O_VALID !== 1'b0) begin n_err++; $display("[TB] FAIL midreset_early_valid: got %0b want 0", O_VALID); end
        send(8'sd4);
        n_cmp++; if (O_MAX !== 8'sd4 || O_IDX !== 2'd3) begin
            n_err++; $display("[TB] FAIL midreset_result: got max=%0d idx=%0d want 4/3", O_MAX, O_IDX);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_reset_in_hold();
        O_READY = 1'b0;
        send(-8'sd7); send(8'sd9); send(8'sd2); send(8'sd1);
        n_cmp++; if (O_VALID !== 1'b1) begin n_err++; $display("[TB] FAIL holdreset_pre: got %0b want 1", O_VALID); end
        RESETN = 1'b0;
        @(posedge CLK); #1;
        RESETN = 1'b1;
        n_cmp++; if (O_VALID !== 1'b0) begin n_err++; $display("[TB] FAIL holdreset_valid: got %0b want 0", O_VALID); end
        n_cmp++; if (O_MAX !== '0 || O_IDX !== '0) begin n_err++; $display("[TB] FAIL holdreset_out: got %0d/%0d want 0/0", O_MAX, O_IDX); end
        n_cmp++; if (I_READY !== 1'b1) begin n_err++; $display("[TB] FAIL holdreset_ready: got %0b want 1", I_READY); end
        O_READY = 1'b1;
    endtask

    task automatic test_random();
        logic signed [W-1:0] q[$];
        logic signed [W-1:0] emax, emin;
        logic [IW-1:0]       eidx, emini;
        bit                  hold;
        do_reset();
        hold = 1'b0;
        emax = '0; eidx = '0; emin = '0; emini = '0;
        for (int c = 0; c < 400; c++) begin
            I_VALID = ($urandom_range(0, 3) != 0);
            O_READY = ($urandom_range(0, 2) != 0);
            I = W'($urandom);
            if (!hold) begin
                if (I_VALID) begin
                    q.push_back(I);
                    if (q.size() == FL) begin
                        frame_result(q, emax, eidx, emin, emini);
                        q.delete();
                        hold = 1'b1;
                    end
                end
            end else if (O_READY) begin
                hold = 1'b0;
            end
            @(posedge CLK); #1;
            n_cmp++; if (O_VALID !== hold) begin n_err++; $display("[TB] FAIL rnd_valid c%0d: got %0b want %0b", c, O_VALID, hold); end
            n_cmp++; if (I_READY !== !hold) begin n_err++; $display("[TB] FAIL rnd_ready c%0d: got %0b want %0b", c, I_READY, !hold); end
            if (hold) begin
                n_cmp++; if (O_MAX !== emax || O_IDX !== eidx) begin
                    n_err++; $display("[TB] FAIL rnd_result c%0d: got %0d/%0d want %0d/%0d", c, O_MAX, O_IDX, emax, eidx);
                end
`ifdef SIGNED_PEAK_TRACKER_MIN_EN
                n_cmp++; if (O_MIN !== emin || O_MIN_IDX !== emini) begin
                    n_err++; $display("[TB] FAIL rnd_min c%0d: got %0d/%0d want %0d/%0d", c, O_MIN, O_MIN_IDX, emin, emini);
                end
`endif
            end
        end
        I_VALID = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        RESETN = 1'b0;
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_frame();
        test_reset_in_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
